// File: rtl/if_fetch_req_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch request controller.
// Cancel states double as the number of responses still to be discarded.
package if_fetch_req_ctrl_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 64;
   localparam int MAX_OUT_DEF = 2;

   typedef enum logic [1:0] {
      CLEAN   = 2'b00,
      CANCEL1 = 2'b01,
      CANCEL2 = 2'b10
   } cancel_state_e;

   localparam logic [1:0] CE_IDLE  = 2'b00;
   localparam logic [1:0] CE_WRITE = 2'b10;
   localparam logic [1:0] CE_USED  = 2'b01;

   // Pending-discard count to cancel state; at most two requests can be in flight.
   function automatic cancel_state_e pend_to_state(input int unsigned pend);
      case (pend)
         0:       return CLEAN;
         1:       return CANCEL1;
         default: return CANCEL2;
      endcase
   endfunction

endpackage

// File: rtl/fetch_rdata_fifo.sv
// Small synchronous FIFO holding returned instruction pairs until IF takes them.
// A synchronous clear drops every entry on a flush.
module fetch_rdata_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push && rst_n && !clear) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_req_ctrl.sv
// Fetch-side initiator of the SRAM-like instruction bus: issues requests, counts
// outstanding ones, drops responses killed by a flush and buffers the rest for IF.
module if_fetch_req_ctrl
   import if_fetch_req_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF,
   localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   input  logic [ADDR_W-1:0] req_pc_i,
   output logic              req_accept_o,
   input  logic              flush_i,
   output logic              inst_req_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_addr_ok_i,
   input  logic              inst_data_ok_i,
   input  logic [DATA_W-1:0] inst_rdata_i,
   output logic              rdata_valid_o,
   output logic [DATA_W-1:0] rdata_o,
   input  logic              rdata_ready_i,
   output logic [1:0]        inst_rdata_ce_we_o,
   output logic              cancel_busy_o,
   output cancel_state_e     dbg_state_o,
   output logic [CNT_W-1:0]  dbg_out_cnt_o,
   output logic [CNT_W-1:0]  dbg_fifo_cnt_o
);

   // Handshakes: the bus takes an address when inst_req_o & inst_addr_ok_i, and
   // returns one data beat per accepted address on inst_data_ok_i in order; IF
   // takes rdata_o when rdata_valid_o & rdata_ready_i.

   cancel_state_e     state, state_nxt;
   logic [CNT_W-1:0]  out_cnt, out_cnt_nxt;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [CNT_W-1:0]  flush_pend;
   logic [CNT_W:0]    in_use;
   logic [1:0]        ce_we_nxt;
   logic              addr_hs;
   logic              data_ok;
   logic              discard;
   logic              live;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;

   // Outstanding requests plus buffered pairs bound the FIFO, so it cannot overflow.
   assign in_use      = {1'b0, out_cnt} + {1'b0, fifo_cnt};
   assign inst_req_o  = rst_n & req_valid_i & ~flush_i & (in_use < (CNT_W + 1)'(MAX_OUT));
   assign inst_addr_o = req_pc_i;
   assign addr_hs     = inst_req_o & inst_addr_ok_i;
   assign req_accept_o = addr_hs;

   // A data beat with nothing outstanding is a bus protocol error and is ignored.
   assign data_ok = inst_data_ok_i & (out_cnt != '0);
   assign discard = data_ok & ((state != CLEAN) | flush_i);
   assign live    = data_ok & ~discard;

   // Requests still in flight after this edge all belong to the flushed stream.
   assign flush_pend = out_cnt - CNT_W'(data_ok);

   always_comb begin
      out_cnt_nxt = out_cnt;
      if (addr_hs && !data_ok) out_cnt_nxt = out_cnt + CNT_W'(1);
      else if (!addr_hs && data_ok) out_cnt_nxt = out_cnt - CNT_W'(1);
   end

   always_comb begin
      state_nxt = state;
      ce_we_nxt = CE_IDLE;
      if (flush_i) begin
         state_nxt = pend_to_state(32'(flush_pend));
      end else if (data_ok) begin
         case (state)
            CANCEL1: state_nxt = CLEAN;
            CANCEL2: state_nxt = CANCEL1;
            default: state_nxt = state;
         endcase
      end
      if (flush_i && (flush_pend != '0)) ce_we_nxt = CE_WRITE;
      else if (discard && (state != CLEAN)) ce_we_nxt = CE_USED;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state              <= CLEAN;
         out_cnt            <= '0;
         inst_rdata_ce_we_o <= CE_IDLE;
      end else begin
         state              <= state_nxt;
         out_cnt            <= out_cnt_nxt;
         inst_rdata_ce_we_o <= ce_we_nxt;
      end
   end

   // Empty FIFO forwards the bus beat directly; only an unaccepted beat is stored.
   assign fifo_push = fifo_empty ? (live & ~rdata_ready_i) : live;
   assign fifo_pop  = ~fifo_empty & rdata_ready_i & ~flush_i;

   fetch_rdata_fifo #(
      .DEPTH (MAX_OUT),
      .W     (DATA_W)
   ) u_rdata_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (inst_rdata_i),
      .head  (fifo_head),
      .count (fifo_cnt),
      .empty (fifo_empty)
   );

   assign rdata_valid_o = rst_n & ~flush_i & (fifo_empty ? live : 1'b1);
   assign rdata_o       = rdata_valid_o ? (fifo_empty ? inst_rdata_i : fifo_head) : '0;

   assign cancel_busy_o  = (state != CLEAN);
   assign dbg_state_o    = state;
   assign dbg_out_cnt_o  = out_cnt;
   assign dbg_fifo_cnt_o = fifo_cnt;

endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
// Bench for if_fetch_req_ctrl: directed scenarios then random traffic, all checked
// against a request-queue model of in-flight fetches and buffered pairs.
module tb_if_fetch_req_ctrl;
   import if_fetch_req_ctrl_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 64;
   localparam int MAX_OUT = 2;
   localparam int CNT_W   = $clog2(MAX_OUT + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic [ADDR_W-1:0] req_pc;
   logic              req_accept;
   logic              flush;
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata_in;
   logic              rdata_valid;
   logic [DATA_W-1:0] rdata;
   logic              rdata_ready;
   logic [1:0]        ce_we;
   logic              cancel_busy;
   cancel_state_e     dbg_state;
   logic [CNT_W-1:0]  dbg_out_cnt;
   logic [CNT_W-1:0]  dbg_fifo_cnt;

   // Model: one entry per accepted address (1 = killed by a flush), plus buffered data.
   bit                inflight_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [1:0]        exp_ce;

   int checks = 0;
   int errors = 0;

   if_fetch_req_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_i        (req_valid),
      .req_pc_i           (req_pc),
      .req_accept_o       (req_accept),
      .flush_i            (flush),
      .inst_req_o         (inst_req),
      .inst_addr_o        (inst_addr),
      .inst_addr_ok_i     (addr_ok),
      .inst_data_ok_i     (data_ok),
      .inst_rdata_i       (rdata_in),
      .rdata_valid_o      (rdata_valid),
      .rdata_o            (rdata),
      .rdata_ready_i      (rdata_ready),
      .inst_rdata_ce_we_o (ce_we),
      .cancel_busy_o      (cancel_busy),
      .dbg_state_o        (dbg_state),
      .dbg_out_cnt_o      (dbg_out_cnt),
      .dbg_fifo_cnt_o     (dbg_fifo_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [ADDR_W-1:0] pc, input logic fl,
                        input logic aok, input logic dok, input logic [DATA_W-1:0] d,
                        input logic rdy);
      req_valid   = rv;
      req_pc      = pc;
      flush       = fl;
      addr_ok     = aok;
      data_ok     = dok;
      rdata_in    = d;
      rdata_ready = rdy;
   endtask

   // Checks one cycle against the model, then advances model and clock to the next negedge.
   task automatic step();
      int  n_out, n_kill, n_new;
      bit  e_req, e_hs, dok, head_killed, drop, live, e_valid;
      logic [DATA_W-1:0] e_data;
      #1;
      n_out  = inflight_q.size();
      n_kill = 0;
      foreach (inflight_q[i]) if (inflight_q[i]) n_kill++;
      e_req       = rst_n && req_valid && !flush && (n_out + exp_q.size() < MAX_OUT);
      e_hs        = e_req && addr_ok;
      dok         = rst_n && data_ok && (n_out > 0);
      head_killed = dok && inflight_q[0];
      drop        = dok && (head_killed || flush);
      live        = dok && !drop;
      e_valid     = rst_n && !flush && (exp_q.size() > 0 || live);
      e_data      = (exp_q.size() > 0) ? exp_q[0] : rdata_in;

      check("inst_req", 64'(inst_req), 64'(e_req));
      check("req_accept", 64'(req_accept), 64'(e_hs));
      check("inst_addr", 64'(inst_addr), 64'(req_pc));
      check("rdata_valid", 64'(rdata_valid), 64'(e_valid));
      if (e_valid) check("rdata", rdata, e_data);
      if (!rst_n) check("rdata_in_reset", rdata, 64'h0);
      check("ce_we", 64'(ce_we), 64'(exp_ce));
      check("cancel_state", 64'(dbg_state), 64'(n_kill));
      check("cancel_busy", 64'(cancel_busy), 64'(n_kill != 0));
      check("out_cnt", 64'(dbg_out_cnt), 64'(n_out));
      check("fifo_cnt", 64'(dbg_fifo_cnt), 64'(exp_q.size()));
      check("no_overflow", 64'(int'(dbg_out_cnt) + int'(dbg_fifo_cnt) <= MAX_OUT), 64'(1));

      if (!rst_n) begin
         inflight_q.delete();
         exp_q.delete();
         exp_ce = 2'b00;
      end else begin
         if (dok) void'(inflight_q.pop_front());
         if (flush) begin
            foreach (inflight_q[i]) inflight_q[i] = 1'b1;
            exp_q.delete();
            n_new  = inflight_q.size();
            exp_ce = (n_new > 0) ? 2'b10 : (head_killed ? 2'b01 : 2'b00);
         end else begin
            exp_ce = head_killed ? 2'b01 : 2'b00;
            if (exp_q.size() > 0) begin
               if (rdata_ready) void'(exp_q.pop_front());
               if (live) exp_q.push_back(rdata_in);
            end else if (live && !rdata_ready) begin
               exp_q.push_back(rdata_in);
            end
         end
         if (e_hs) inflight_q.push_back(1'b0);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [ADDR_W-1:0] pc, input logic rdy);
      drive(1'b1, pc, 1'b0, 1'b1, 1'b0, '0, rdy);
      step();
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, rdy);
   endtask

   initial begin
      exp_ce = 2'b00;
      rst_n  = 1'b0;
      drive(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, 64'h1234, 1'b1);
      #1;
      check("reset_req_blocked", 64'(inst_req), 64'(0));
      step();
      step();
      rst_n = 1'b1;

      // single fetch
      drive(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      #1;
      check("single_accept", 64'(req_accept), 64'(1));
      check("single_addr", 64'(inst_addr), 64'h1C00_0000);
      step();
      idle(1'b1);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h0280_0400_0280_0000, 1'b1);
      #1;
      check("single_valid", 64'(rdata_valid), 64'(1));
      check("single_data", rdata, 64'h0280_0400_0280_0000);
      step();
      idle(1'b1);
      #1;
      check("single_out_cnt", 64'(dbg_out_cnt), 64'(0));
      step();

      // backpressure
      issue(32'h1C00_0008, 1'b0);
      issue(32'h1C00_0010, 1'b0);
      drive(1'b1, 32'h1C00_0018, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      #1;
      check("bp_req_held", 64'(inst_req), 64'(0));
      step();
      drive(1'b1, 32'h1C00_0018, 1'b0, 1'b1, 1'b1, 64'hD0D0_0000_0000_00D0, 1'b0);
      step();
      drive(1'b1, 32'h1C00_0018, 1'b0, 1'b1, 1'b1, 64'hD1D1_0000_0000_00D1, 1'b0);
      #1;
      check("bp_req_held2", 64'(inst_req), 64'(0));
      step();
      idle(1'b1);
      #1;
      check("bp_first", rdata, 64'hD0D0_0000_0000_00D0);
      step();
      #1;
      check("bp_second", rdata, 64'hD1D1_0000_0000_00D1);
      step();

      // flush with two outstanding
      issue(32'h1C00_0020, 1'b1);
      issue(32'h1C00_0028, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      step();
      idle(1'b1);
      #1;
      check("fl2_ce_write", 64'(ce_we), 64'(2'b10));
      check("fl2_state", 64'(dbg_state), 64'(CANCEL2));
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hBAD0, 1'b1);
      #1;
      check("fl2_drop1", 64'(rdata_valid), 64'(0));
      step();
      idle(1'b1);
      #1;
      check("fl2_ce_used1", 64'(ce_we), 64'(2'b01));
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hBAD1, 1'b1);
      step();
      idle(1'b1);
      #1;
      check("fl2_ce_used2", 64'(ce_we), 64'(2'b01));
      check("fl2_clean", 64'(dbg_state), 64'(CLEAN));
      step();
      issue(32'h1C00_0030, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hF00D_F00D_0000_0001, 1'b1);
      #1;
      check("fl2_after_fwd", rdata, 64'hF00D_F00D_0000_0001);
      step();

      // flush coinciding with data_ok
      issue(32'h1C00_0040, 1'b1);
      issue(32'h1C00_0048, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 64'hBAD2, 1'b1);
      #1;
      check("fld_drop", 64'(rdata_valid), 64'(0));
      step();
      idle(1'b1);
      #1;
      check("fld_state", 64'(dbg_state), 64'(CANCEL1));
      check("fld_ce_write", 64'(ce_we), 64'(2'b10));
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hBAD3, 1'b1);
      step();
      idle(1'b1);
      step();
      issue(32'h1C00_0050, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h600D_0000_0000_0002, 1'b1);
      #1;
      check("fld_after_fwd", 64'(rdata_valid), 64'(1));
      step();

      // flush with one buffered entry and nothing outstanding
      issue(32'h1C00_0060, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hAAAA_5555_AAAA_5555, 1'b0);
      step();
      idle(1'b0);
      #1;
      check("flf_buffered", 64'(dbg_fifo_cnt), 64'(1));
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      step();
      idle(1'b1);
      #1;
      check("flf_empty", 64'(dbg_fifo_cnt), 64'(0));
      check("flf_ce_idle", 64'(ce_we), 64'(2'b00));
      step();

      // stray data_ok with nothing outstanding
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b1);
      step();
      idle(1'b1);
      #1;
      check("stray_out_cnt", 64'(dbg_out_cnt), 64'(0));
      step();

      // reset with two outstanding and a discard pending
      issue(32'h1C00_0070, 1'b1);
      issue(32'h1C00_0078, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 64'hBAD4, 1'b1);
      step();
      issue(32'h1C00_0080, 1'b1);
      rst_n = 1'b0;
      drive(1'b1, 32'h1C00_0088, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      step();
      rst_n = 1'b1;
      idle(1'b1);
      #1;
      check("rst_out_cnt", 64'(dbg_out_cnt), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(CLEAN));
      step();

      // random traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 9) < 6),
               (inflight_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0),
               {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
